// File: rtl/io_pkg.sv
// Shared types and constants for the basic-computer I/O and interrupt controller.
package io_pkg;

   localparam int CHAR_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RT0  = 2'd1,
      RT1  = 2'd2,
      RT2  = 2'd3
   } state_t;

   localparam logic [2:0] BUS_NONE = 3'b000;
   localparam logic [2:0] BUS_PC   = 3'b010;
   localparam logic [2:0] BUS_TR   = 3'b110;

endpackage

// File: rtl/io_out_fifo.sv
// Two-entry character FIFO between the OUT instruction and the terminal.
// Only instantiated when OUT_BUF_EN is defined.
module io_out_fifo
   import io_pkg::*;
#(
   parameter int W = CHAR_W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_head,
   output logic         o_full,
   output logic         o_empty
);

   logic [W-1:0] r_mem [2];
   logic         r_wr_ptr;
   logic         r_rd_ptr;
   logic [1:0]   r_cnt;
   logic         w_push;
   logic         w_pop;

   // A push while full is dropped, so push and pop never race on the same slot.
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_full  = (r_cnt == 2'd2);
   assign o_empty = (r_cnt == 2'd0);
   assign o_head  = r_mem[r_rd_ptr];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ent
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               r_mem[gi] <= '0;
            else if (w_push && (r_wr_ptr == 1'(gi)))
               r_mem[gi] <= i_data;
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_cnt    <= 2'd0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/io_intr_ctrl.sv
// I/O flags, INPR/OUTR terminal handshakes and the three-step interrupt cycle.
// Optional OUT_BUF_EN replaces OUTR with a two-entry output FIFO.
module io_intr_ctrl
   import io_pkg::*;
#(
   parameter int              WIDTH   = 16,
   parameter int              CHAR_W  = CHAR_W_DEF,
   parameter logic [WIDTH-5:0] INT_VEC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              io_inp,
   input  logic              io_out,
   input  logic              io_ski,
   input  logic              io_sko,
   input  logic              io_ion,
   input  logic              io_iof,
   input  logic              fetch_phase,
   input  logic              int_grant,
   input  logic [CHAR_W-1:0] ac_lo,
   input  logic              in_valid,
   input  logic [CHAR_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [CHAR_W-1:0] out_data,
   input  logic              out_ready,
   output logic [CHAR_W-1:0] inpr,
   output logic              ac_ld_inpr,
   output logic              skip,
   output logic              int_req,
   output logic              int_active,
   output logic              int_done,
   output logic [2:0]        int_bus_sel,
   output logic              ar_ld_vec,
   output logic              tr_ld,
   output logic              mem_wr,
   output logic              pc_ld_vec,
   output logic              pc_inr,
   output logic              sc_clr,
   output logic [WIDTH-5:0]  int_vec
);

   logic              r_fgi;
   logic              r_ien;
   logic              r_r;
   logic [CHAR_W-1:0] r_inpr;
   state_t            r_state;
   logic              w_fgo;
   logic              w_accept;

   assign w_accept   = in_valid & ~r_fgi;
   assign in_ready   = ~r_fgi;
   assign inpr       = r_inpr;
   assign ac_ld_inpr = io_inp;
   assign skip       = (io_ski & r_fgi) | (io_sko & w_fgo);
   assign int_req    = r_r;
   assign int_vec    = INT_VEC;

   // A terminal accept outranks INP's clear on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fgi  <= 1'b0;
         r_inpr <= '0;
      end else if (w_accept) begin
         r_fgi  <= 1'b1;
         r_inpr <= in_data;
      end else if (io_inp) begin
         r_fgi  <= 1'b0;
      end
   end

`ifdef OUT_BUF_EN
   logic w_full;
   logic w_empty;

   io_out_fifo #(.W(CHAR_W)) u_out_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (io_out),
      .i_data  (ac_lo),
      .i_pop   (out_ready),
      .o_head  (out_data),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_fgo     = ~w_full;
   assign out_valid = ~w_empty;
`else
   logic              r_fgo;
   logic              r_out_valid;
   logic [CHAR_W-1:0] r_outr;

   assign w_fgo     = r_fgo;
   assign out_valid = r_out_valid;
   assign out_data  = r_outr;

   // FGO=0 exactly while a character is offered, so OUT and the handshake never collide.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fgo       <= 1'b1;
         r_out_valid <= 1'b0;
         r_outr      <= '0;
      end else if (r_out_valid && out_ready) begin
         r_fgo       <= 1'b1;
         r_out_valid <= 1'b0;
      end else if (io_out && r_fgo) begin
         r_fgo       <= 1'b0;
         r_out_valid <= 1'b1;
         r_outr      <= ac_lo;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ien <= 1'b0;
         r_r   <= 1'b0;
      end else begin
         if (r_state == RT2)  r_ien <= 1'b0;
         else if (io_ion)     r_ien <= 1'b1;
         else if (io_iof)     r_ien <= 1'b0;

         if (r_state == RT2)
            r_r <= 1'b0;
         else if (!fetch_phase && r_ien && (r_fgi || w_fgo) && r_state == IDLE)
            r_r <= 1'b1;
      end
   end

   // Strobes are registered alongside the state they belong to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         int_bus_sel <= BUS_NONE;
         int_active  <= 1'b0;
         int_done    <= 1'b0;
         ar_ld_vec   <= 1'b0;
         tr_ld       <= 1'b0;
         mem_wr      <= 1'b0;
         pc_ld_vec   <= 1'b0;
         pc_inr      <= 1'b0;
         sc_clr      <= 1'b0;
      end else begin
         int_bus_sel <= BUS_NONE;
         int_active  <= 1'b0;
         int_done    <= 1'b0;
         ar_ld_vec   <= 1'b0;
         tr_ld       <= 1'b0;
         mem_wr      <= 1'b0;
         pc_ld_vec   <= 1'b0;
         pc_inr      <= 1'b0;
         sc_clr      <= 1'b0;
         case (r_state)
            IDLE: if (r_r && int_grant) begin
               r_state     <= RT0;
               int_bus_sel <= BUS_PC;
               int_active  <= 1'b1;
               ar_ld_vec   <= 1'b1;
               tr_ld       <= 1'b1;
            end
            RT0: begin
               r_state     <= RT1;
               int_bus_sel <= BUS_TR;
               int_active  <= 1'b1;
               mem_wr      <= 1'b1;
               pc_ld_vec   <= 1'b1;
            end
            RT1: begin
               r_state     <= RT2;
               int_active  <= 1'b1;
               int_done    <= 1'b1;
               pc_inr      <= 1'b1;
               sc_clr      <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_io_intr_ctrl.sv
// Directed bench for io_intr_ctrl with a queue-based flag model checked every cycle.
module tb_io_intr_ctrl;

`ifdef OUT_BUF_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   logic clk = 0;
   logic rst = 0;
   logic io_inp = 0, io_out = 0, io_ski = 0, io_sko = 0, io_ion = 0, io_iof = 0;
   logic fetch_phase = 1, int_grant = 0;
   logic [7:0] ac_lo = 0, in_data = 0;
   logic in_valid = 0, out_ready = 0;
   logic in_ready, out_valid, ac_ld_inpr, skip, int_req, int_active, int_done;
   logic ar_ld_vec, tr_ld, mem_wr, pc_ld_vec, pc_inr, sc_clr;
   logic [7:0] out_data, inpr;
   logic [2:0] int_bus_sel;
   logic [11:0] int_vec;

   int n_chk = 0;
   int n_fail = 0;
   bit en_cmp = 0;

   always #5 clk = ~clk;

   io_intr_ctrl dut (
      .clk(clk), .rst(rst),
      .io_inp(io_inp), .io_out(io_out), .io_ski(io_ski), .io_sko(io_sko),
      .io_ion(io_ion), .io_iof(io_iof),
      .fetch_phase(fetch_phase), .int_grant(int_grant), .ac_lo(ac_lo),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .inpr(inpr), .ac_ld_inpr(ac_ld_inpr), .skip(skip),
      .int_req(int_req), .int_active(int_active), .int_done(int_done),
      .int_bus_sel(int_bus_sel), .ar_ld_vec(ar_ld_vec), .tr_ld(tr_ld),
      .mem_wr(mem_wr), .pc_ld_vec(pc_ld_vec), .pc_inr(pc_inr), .sc_clr(sc_clr),
      .int_vec(int_vec)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   // Model: flags as booleans, output path as a bounded queue, interrupt step as a number 0..3.
   bit         m_fgi, m_ien, m_r;
   logic [7:0] m_inpr;
   logic [7:0] m_q[$];
   int         m_ph;

   function automatic bit m_fgo();
      return m_q.size() < DEPTH;
   endfunction

   task automatic model_reset();
      m_fgi = 0; m_ien = 0; m_r = 0; m_inpr = 0; m_ph = 0;
      m_q.delete();
   endtask

   task automatic model_step();
      bit fgi0, fgo0, ien0, r0, do_push, do_pop;
      int ph0;
      fgi0 = m_fgi; fgo0 = m_fgo(); ien0 = m_ien; r0 = m_r; ph0 = m_ph;
      do_push = io_out && fgo0;
      do_pop  = out_ready && m_q.size() > 0;
      if (in_valid && !fgi0) begin
         m_fgi = 1; m_inpr = in_data;
      end else if (io_inp) m_fgi = 0;
      if (do_pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back(ac_lo);
      if (ph0 == 3) m_ien = 0;
      else if (io_ion) m_ien = 1;
      else if (io_iof) m_ien = 0;
      if (ph0 == 3) m_r = 0;
      else if (!fetch_phase && ien0 && (fgi0 || fgo0) && ph0 == 0) m_r = 1;
      if (ph0 == 0) m_ph = (r0 && int_grant) ? 1 : 0;
      else m_ph = (ph0 + 1) % 4;
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
   end

   task automatic compare();
      logic [2:0] e_sel;
      logic [5:0] e_str;  // {ar_ld_vec, tr_ld, mem_wr, pc_ld_vec, pc_inr, sc_clr}
      case (m_ph)
         1: begin e_sel = 3'b010; e_str = 6'b110000; end
         2: begin e_sel = 3'b110; e_str = 6'b001100; end
         3: begin e_sel = 3'b000; e_str = 6'b000011; end
         default: begin e_sel = 3'b000; e_str = 6'b000000; end
      endcase
      chk("in_ready", in_ready, !m_fgi);
      chk("inpr", inpr, m_inpr);
      chk("out_valid", out_valid, m_q.size() > 0);
      if (m_q.size() > 0) chk("out_data", out_data, m_q[0]);
      chk("ac_ld_inpr", ac_ld_inpr, io_inp);
      chk("skip", skip, (io_ski && m_fgi) || (io_sko && m_fgo()));
      chk("int_req", int_req, m_r);
      chk("int_active", int_active, m_ph != 0);
      chk("int_done", int_done, m_ph == 3);
      chk("int_bus_sel", int_bus_sel, e_sel);
      chk("strobes", {ar_ld_vec, tr_ld, mem_wr, pc_ld_vec, pc_inr, sc_clr}, e_str);
      chk("int_vec", int_vec, 12'h000);
   endtask

   initial forever begin
      @(negedge clk);
      if (en_cmp) compare();
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2 rst = 1;
      #1 en_cmp = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;

      // Reset state, FGO probed through SKO
      io_sko = 1;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_int_req", int_req, 0);
      chk("rst_fgo_skip", skip, 1);
      tick(); io_sko = 0;

      // Input character, SKI, INP
      in_data = 8'h41; in_valid = 1;
      tick(); in_valid = 0; io_ski = 1;
      @(negedge clk);
      chk("inp_data", inpr, 8'h41);
      chk("inp_ready", in_ready, 0);
      chk("ski_skip", skip, 1);
      tick(); io_ski = 0; io_inp = 1;
      @(negedge clk);
      chk("inp_strobe", ac_ld_inpr, 1);
      tick(); io_inp = 0;
      @(negedge clk);
      chk("inp_clr", in_ready, 1);

      // Accept and INP on the same edge: set wins
      in_data = 8'h77; in_valid = 1; io_inp = 1;
      tick(); in_valid = 0; io_inp = 0;
      @(negedge clk);
      chk("setwin_ready", in_ready, 0);
      chk("setwin_data", inpr, 8'h77);
      io_inp = 1;
      tick(); io_inp = 0;

      // OUT with terminal stalled, second OUT ignored
      ac_lo = 8'h5A; io_out = 1;
      tick(); io_out = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("out_hold_v", out_valid, 1);
         chk("out_hold_d", out_data, 8'h5A);
         tick();
      end
      io_sko = 1;
      @(negedge clk);
      chk("sko_skip", skip, 0);
      tick(); io_sko = 0; ac_lo = 8'h11; io_out = 1;
      tick(); io_out = 0;
      @(negedge clk);
      chk("out_ignored", out_data, 8'h5A);
      out_ready = 1;
      tick(); out_ready = 0; io_sko = 1;
      @(negedge clk);
      chk("out_done_v", out_valid, 0);
      chk("out_done_fgo", skip, 1);
      tick(); io_sko = 0;

      // Interrupt cycle, with a terminal accept and an ION racing RT2
      fetch_phase = 0; io_ion = 1;
      tick(); io_ion = 0;
      tick();
      @(negedge clk);
      chk("r_set", int_req, 1);
      int_grant = 1;
      tick(); int_grant = 0; in_data = 8'h33; in_valid = 1;
      @(negedge clk);
      chk("rt0_sel", int_bus_sel, 3'b010);
      chk("rt0_ar_tr", {ar_ld_vec, tr_ld}, 2'b11);
      tick(); in_valid = 0;
      @(negedge clk);
      chk("rt1_sel", int_bus_sel, 3'b110);
      chk("rt1_wr_pc", {mem_wr, pc_ld_vec}, 2'b11);
      io_ion = 1;
      tick(); io_ion = 0;
      @(negedge clk);
      chk("rt2_done", {pc_inr, sc_clr, int_done}, 3'b111);
      tick();
      @(negedge clk);
      chk("rt_end_r", int_req, 0);
      chk("rt_end_act", int_active, 0);
      repeat (3) tick();
      @(negedge clk);
      chk("ien_cleared", int_req, 0);

      // Asynchronous reset in RT1
      io_ion = 1;
      tick(); io_ion = 0;
      tick(); int_grant = 1;
      tick(); int_grant = 0;
      tick();
      chk("pre_rst_rt1", mem_wr, 1);
      rst = 1;
      #1;
      chk("arst_act", int_active, 0);
      chk("arst_wr", mem_wr, 0);
      chk("arst_sel", int_bus_sel, 3'b000);
      chk("arst_req", int_req, 0);
      chk("arst_ready", in_ready, 1);
      chk("arst_ov", out_valid, 0);
      tick(); rst = 0;
      repeat (3) tick();
      @(negedge clk);
      chk("post_rst_idle", int_active, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/io_intr_ctrl.md
Name: io_intr_ctrl

Overview:
- Input/output and interrupt controller for the 16-bit basic computer.
- Owns the I/O flags (FGI, FGO, IEN, R) and the 8-bit INPR/OUTR character registers.
- Exchanges characters with an external terminal over valid/ready handshakes.
- Sequences the three-step interrupt cycle on the common bus when the main controller grants it.
- Sits beside the main instruction controller, which decodes I/O instructions (D7·I·T3) and forwards them as one-hot strobes.

Parameters:
- WIDTH, 16, datapath word width.
- CHAR_W, 8, terminal character width; INPR/OUTR width.
- INT_VEC, 12'h000, address where the return PC is saved; execution resumes at INT_VEC+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- io_inp / io_out / io_ski / io_sko / io_ion / io_iof  in  1 each  one-hot instruction strobes from the controller, one cycle wide.
- fetch_phase  in  1  high while the sequence counter is at T0, T1 or T2.
- int_grant  in  1  controller yields the bus; sampled only while int_req is high.
- ac_lo  in  CHAR_W  AC(7-0), used by OUT.
- in_valid  in  1  / in_data  in  CHAR_W  / in_ready  out  1  terminal input handshake.
- out_valid  out  1  / out_data  out  CHAR_W  / out_ready  in  1  terminal output handshake.
- inpr  out  CHAR_W  INPR contents.
- ac_ld_inpr  out  1  AC(7-0) <- INPR strobe.
- skip  out  1  PC <- PC+1 request.
- int_req  out  1  equals R.
- int_active  out  1  interrupt cycle in progress.
- int_done  out  1  one-cycle pulse in the last interrupt step.
- int_bus_sel  out  3  bus source during the interrupt cycle.
- ar_ld_vec, tr_ld, mem_wr, pc_ld_vec, pc_inr, sc_clr  out  1 each  datapath strobes.
- int_vec  out  12  constant INT_VEC.

Behaviour:
- Reset (asynchronous, immediate, also mid-interrupt):
  - FGI=0, FGO=1, IEN=0, R=0, INPR=0, OUTR=0, state=IDLE.
  - out_valid=0, in_ready=1, all strobes 0, int_bus_sel=BUS_NONE.
- Input path:
  - in_ready = ~FGI.
  - On in_valid & in_ready: INPR<=in_data and FGI<=1 at the same edge.
- INP:
  - ac_ld_inpr = io_inp, combinational, same cycle.
  - FGI<=0 at the edge.
  - If an accept happens on the same edge, the set wins (FGI=1, new INPR).
- OUT:
  - When FGO=1: OUTR<=ac_lo, FGO<=0, out_valid<=1.
  - When FGO=0: ignored; OUTR is held stable.
- Output handshake:
  - out_data=OUTR.
  - On out_valid & out_ready: out_valid<=0, FGO<=1.
  - out_valid, once high, never drops without out_ready.
- Skip and enable:
  - skip = (io_ski&FGI) | (io_sko&FGO), combinational.
  - ION: IEN<=1. IOF: IEN<=0.
- R flag:
  - Set at an edge when ~fetch_phase & IEN & (FGI|FGO) & state==IDLE.
  - Cleared only in RT2 or by reset.
- FSM: IDLE -> RT0 -> RT1 -> RT2 -> IDLE.
  - IDLE -> RT0 on int_req & int_grant.
  - RT0: int_bus_sel=BUS_PC, ar_ld_vec=1, tr_ld=1 (AR<-INT_VEC, TR<-PC).
  - RT1: int_bus_sel=BUS_TR, mem_wr=1, pc_ld_vec=1 (M[AR]<-TR, PC<-INT_VEC).
  - RT2: pc_inr=1, sc_clr=1, int_done=1; IEN<=0, R<=0.
  - int_active is high in RT0..RT2. The grant-to-RT0 latency is 1 cycle.
- Priority: in RT2, IEN clear beats a simultaneous io_ion.
- Terminal handshakes continue during the interrupt cycle.
- The flag update order within one edge is set-by-terminal over clear-by-instruction.

Optional Feature:
- Macro: OUT_BUF_EN.
- When defined: a two-entry output FIFO sits between OUTR and the terminal.
  - FGO reads 1 whenever the FIFO is not full.
  - OUT pushes AC(7-0); out_valid means FIFO not empty; out_data is the FIFO head.
  - OUT with the FIFO full is ignored.
- When undefined: single OUTR register and behaviour exactly as above.

Decomposition:
- Package io_pkg holds:
  - state enum (IDLE, RT0, RT1, RT2);
  - bus select constants BUS_NONE=3'b000, BUS_PC=3'b010, BUS_TR=3'b110;
  - CHAR_W default.
- One natural sub-module, io_out_fifo (depth 2), instantiated only under OUT_BUF_EN.

Test Plan:
1. Reset, then idle -> FGI=0, FGO=1, IEN=0, int_req=0, in_ready=1, out_valid=0.
2. in_valid with in_data=8'h41 for 1 cycle -> FGI=1, inpr=8'h41, in_ready=0. Then io_inp -> ac_ld_inpr=1 that cycle; FGI=0 next cycle.
3. ac_lo=8'h5A, io_out with out_ready=0 for 3 cycles -> out_valid=1, out_data=8'h5A held, FGO=0. A second io_out with ac_lo=8'h11 is ignored. Then out_ready=1 -> out_valid=0, FGO=1.
4. io_ski with FGI=1 -> skip=1. io_sko with FGO=0 -> skip=0.
5. io_ion, FGO=1, fetch_phase=0 -> R=1. Then int_grant -> RT0/RT1/RT2 on 3 consecutive cycles with the exact strobe and int_bus_sel values above, int_done in RT2, then IEN=0, R=0.
6. rst asserted asynchronously in RT1 -> all outputs at reset values before the next clk edge; state=IDLE.
